// File: rtl/if_id_stage_pkg.sv
// Shared pipeline constants and the IF/ID register layout used by the fetch stage.
package if_id_stage_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_STEP  = 32'd4;
  localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
    logic              valid;
  } if_id_t;

  // Branch targets are forced onto a word boundary before they reach the PC.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter register: synchronous reset to RST_VAL, loads d only when en is high.
module pc_reg #(
  parameter int              W       = 32,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
// Optional stall/flush performance counters are built only when IF_PERF_CNT_EN is defined.
module if_id_stage
  import if_id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_addr,
  output logic [WORD_W-1:0] inst_mem_addr,
  input  logic [WORD_W-1:0] inst_mem_data,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] inst_out,
  output logic              valid_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0] stall_cnt,
  output logic [WORD_W-1:0] flush_cnt
`endif
);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_seq;
  logic [WORD_W-1:0] pc_next;
  logic              pc_en;
  if_id_t            if_id_q;

  // Control semantics: branch_taken wins over freeze and turns IF/ID into a bubble;
  // freeze alone holds both PC and IF/ID; with neither, one word is fetched per cycle.
  assign pc_seq  = pc + PC_STEP;
  assign pc_next = branch_taken ? align_word(branch_addr) : pc_seq;
  assign pc_en   = branch_taken | ~freeze;

  pc_reg #(
    .W       (WORD_W),
    .RST_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_next),
    .q   (pc)
  );

  assign inst_mem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst || branch_taken) begin
      if_id_q.pc    <= '0;
      if_id_q.inst  <= NOP_INST;
      if_id_q.valid <= 1'b0;
    end else if (!freeze) begin
      if_id_q.pc    <= pc_seq;
      if_id_q.inst  <= inst_mem_data;
      if_id_q.valid <= 1'b1;
    end
  end

  assign pc_out    = if_id_q.pc;
  assign inst_out  = if_id_q.inst;
  assign valid_out = if_id_q.valid;

`ifdef IF_PERF_CNT_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze && !branch_taken && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (branch_taken && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: behavioural fetch model feeding an expected queue.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] inst_mem_addr;
  logic [31:0] inst_mem_data;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // {inst_mem_addr, pc_out, inst_out, valid_out}
  logic [96:0] exp_q[$];

  logic [31:0] m_pc, m_pc_out, m_inst;
  logic        m_valid;
  logic [31:0] m_stall, m_flush;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  if_id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .branch_taken  (branch_taken),
    .branch_addr   (branch_addr),
    .inst_mem_addr (inst_mem_addr),
    .inst_mem_data (inst_mem_data),
    .pc_out        (pc_out),
    .inst_out      (inst_out),
    .valid_out     (valid_out)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  // ROM contents: address 0 -> A0000000, 4 -> A0000001, 8 -> A0000002, ...
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA000_0000 ^ {a[1:0], a[31:2]};
  endfunction

  assign inst_mem_data = rom(inst_mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_q.push_back({m_pc, m_pc_out, m_inst, m_valid});
  endtask

  task automatic compare_out();
    logic [96:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("inst_mem_addr", inst_mem_addr, e[96:65]);
      check("pc_out", pc_out, e[64:33]);
      check("inst_out", inst_out, e[32:1]);
      check("valid_out", {31'd0, valid_out}, {31'd0, e[0]});
    end
`ifdef IF_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
`endif
  endtask

  // driver tasks
  task automatic do_reset(input logic f, input logic b);
    rst          = 1'b1;
    freeze       = f;
    branch_taken = b;
    branch_addr  = $urandom;
    m_pc = 32'd0; m_pc_out = 32'd0; m_inst = 32'd0; m_valid = 1'b0;
    m_stall = 32'd0; m_flush = 32'd0;
    push_exp();
    @(posedge clk); #1;
    compare_out();
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic step(input logic f, input logic b, input logic [31:0] ba);
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
    if (b) begin
      m_pc     = {ba[31:2], 2'b00};
      m_pc_out = 32'd0;
      m_inst   = 32'd0;
      m_valid  = 1'b0;
      if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
    end else if (f) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    end else begin
      m_inst   = rom(m_pc);
      m_pc_out = m_pc + 32'd4;
      m_valid  = 1'b1;
      m_pc     = m_pc + 32'd4;
    end
    push_exp();
    @(posedge clk); #1;
    compare_out();
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
    m_stall = 32'd0; m_flush = 32'd0;
    @(posedge clk); #1;

    // reset with freeze and branch asserted must still clear everything
    do_reset(1'b1, 1'b1);
    check("rst_valid", {31'd0, valid_out}, 32'd0);

    // free-running fetch from 0
    step(1'b0, 1'b0, 32'd0);
    check("c1_inst", inst_out, 32'hA000_0000);
    check("c1_pc_out", pc_out, 32'd4);
    step(1'b0, 1'b0, 32'd0);
    check("c2_inst", inst_out, 32'hA000_0001);
    check("c2_pc_out", pc_out, 32'd8);

    // two-cycle freeze at PC=8
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    check("frz_addr", inst_mem_addr, 32'd8);
    check("frz_inst", inst_out, 32'hA000_0001);
    step(1'b0, 1'b0, 32'd0);
    check("rel_inst", inst_out, 32'hA000_0002);
    check("rel_pc_out", pc_out, 32'd12);

    // branch overrides freeze
    step(1'b1, 1'b1, 32'h40);
    check("br_addr", inst_mem_addr, 32'h40);
    check("br_valid", {31'd0, valid_out}, 32'd0);
    check("br_inst", inst_out, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    check("br_fetch", inst_out, 32'hA000_0010);

    // unaligned target
    step(1'b0, 1'b1, 32'h43);
    check("align_addr", inst_mem_addr, 32'h40);

    // wrap at top of address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_top", inst_mem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'd0);
    check("wrap_addr", inst_mem_addr, 32'd0);
    check("wrap_pc_out", pc_out, 32'd0);
    step(1'b0, 1'b0, 32'd0);

    // reset mid-stall, then fetch resumes from 0
    step(1'b1, 1'b0, 32'd0);
    do_reset(1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0);
    check("post_rst_inst", inst_out, 32'hA000_0000);

    // stall/flush counting: 5 freeze cycles, 2 branches, one overlapping
    do_reset(1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h80);
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h100);
`ifdef IF_PERF_CNT_EN
    check("seq_stall_cnt", stall_cnt, 32'd4);
    check("seq_flush_cnt", flush_cnt, 32'd2);
`endif
    step(1'b1, 1'b0, 32'd0);
    do_reset(1'b1, 1'b0);
    check("mid_rst_pc_out", pc_out, 32'd0);

    // random mix of freezes, branches and occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), $urandom);
      end
    end

    if (exp_q.size() != 0) check("exp_q_left", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
